// File: rtl/fb_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// fb_bus_arbiter_if
// Frontend-bus channel bundle shared by ibus, dbus and mbus.
//
// Command channel A : avalid/aready handshake, aaddr, adata, awmsk, aexc
// Response channel B: bvalid/bready handshake, bdata, bexc
//
// Modports
//   master : issues commands and consumes responses (CPU side of a bus)
//   slave  : accepts commands and produces responses (memory side of a bus)
//
// awmsk is a byte write mask; all-zero means the command is a read.
// -----------------------------------------------------------------------------
interface fb_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              avalid;
    logic              aready;
    logic [AW-1:0]     aaddr;
    logic [DW-1:0]     adata;
    logic [DW/8-1:0]   awmsk;
    logic [1:0]        aexc;

    logic              bvalid;
    logic              bready;
    logic [DW-1:0]     bdata;
    logic [1:0]        bexc;

    modport master (
        output avalid, aaddr, adata, awmsk, aexc, bready,
        input  aready, bvalid, bdata, bexc
    );

    modport slave (
        input  avalid, aaddr, adata, awmsk, aexc, bready,
        output aready, bvalid, bdata, bexc
    );
endinterface

// File: rtl/fb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// fb_bus_arbiter
// Two-master / one-slave arbiter for the CPU frontend bus. The instruction bus
// (read-only) and the data bus (read/write) share a single memory bus. Only one
// transaction is ever outstanding on the memory bus.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst      : synchronous, active-high reset; abandons any mbus transaction
//   fb_ibus  : instruction bus, arbiter is the slave (adata/awmsk ignored)
//   fb_dbus  : data bus, arbiter is the slave
//   fb_mbus  : memory bus, arbiter is the master
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no grant; pick an owner from pending requests
// CMD     | owner's command presented on mbus, waiting for mbus aready
// RESP    | command accepted; waiting for mbus B handshake with owner
//
// Round-robin: on a tie the master that was not the last one to have a
// command accepted wins. last_owner resets to ibus so dbus wins the first tie.
// -----------------------------------------------------------------------------
module fb_bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    fb_bus_arbiter_if.slave   fb_ibus,
    fb_bus_arbiter_if.slave   fb_dbus,
    fb_bus_arbiter_if.master  fb_mbus
);

    localparam int MW = DW / 8;

    localparam logic OWN_IBUS = 1'b0;
    localparam logic OWN_DBUS = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   owner;
    logic   owner_nxt;
    logic   last_owner;
    logic   last_owner_nxt;

    // Owner-selected views of the requesting master's control inputs.
    logic          own_avalid;
    logic          own_bready;
    logic [AW-1:0] own_aaddr;
    logic [1:0]    own_aexc;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= OWN_IBUS;
            last_owner <= OWN_IBUS;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Owner mux
    // -------------------------------------------------------------------------
    always_comb begin
        if (owner == OWN_DBUS) begin
            own_avalid = fb_dbus.avalid;
            own_bready = fb_dbus.bready;
            own_aaddr  = fb_dbus.aaddr;
            own_aexc   = fb_dbus.aexc;
        end else begin
            own_avalid = fb_ibus.avalid;
            own_bready = fb_ibus.bready;
            own_aaddr  = fb_ibus.aaddr;
            own_aexc   = fb_ibus.aexc;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;

        case (state)
            ST_IDLE: begin
                if (fb_ibus.avalid && fb_dbus.avalid) begin
                    owner_nxt = ~last_owner;
                    state_nxt = ST_CMD;
                end else if (fb_ibus.avalid) begin
                    owner_nxt = OWN_IBUS;
                    state_nxt = ST_CMD;
                end else if (fb_dbus.avalid) begin
                    owner_nxt = OWN_DBUS;
                    state_nxt = ST_CMD;
                end
            end

            ST_CMD: begin
                if (own_avalid && fb_mbus.aready) begin
                    state_nxt      = ST_RESP;
                    last_owner_nxt = owner;
                end else if (!own_avalid) begin
                    // Owner withdrew its request before acceptance; re-arbitrate.
                    state_nxt = ST_IDLE;
                end
            end

            ST_RESP: begin
                if (fb_mbus.bvalid && own_bready) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // Handshake outputs are forced low while rst is high so that a reset that
    // arrives mid-transaction takes effect on the buses immediately.
    // -------------------------------------------------------------------------
    always_comb begin
        fb_mbus.avalid = 1'b0;
        fb_mbus.aaddr  = '0;
        fb_mbus.adata  = '0;
        fb_mbus.awmsk  = '0;
        fb_mbus.aexc   = '0;
        fb_mbus.bready = 1'b0;

        fb_ibus.aready = 1'b0;
        fb_ibus.bvalid = 1'b0;
        fb_dbus.aready = 1'b0;
        fb_dbus.bvalid = 1'b0;

        if (!rst && (state != ST_IDLE)) begin
            fb_mbus.aaddr = own_aaddr;
            fb_mbus.aexc  = own_aexc;

            // The instruction bus can only read, so its data/mask never reach memory.
            if (owner == OWN_DBUS) begin
                fb_mbus.adata = fb_dbus.adata;
                fb_mbus.awmsk = fb_dbus.awmsk;
            end

            if (state == ST_CMD) begin
                fb_mbus.avalid = own_avalid;
                if (owner == OWN_DBUS) begin
                    fb_dbus.aready = fb_mbus.aready;
                end else begin
                    fb_ibus.aready = fb_mbus.aready;
                end
            end

            if (state == ST_RESP) begin
                fb_mbus.bready = own_bready;
                if (owner == OWN_DBUS) begin
                    fb_dbus.bvalid = fb_mbus.bvalid;
                end else begin
                    fb_ibus.bvalid = fb_mbus.bvalid;
                end
            end
        end
    end

    // Response payload is broadcast; only bvalid selects the receiver.
    assign fb_ibus.bdata = fb_mbus.bdata;
    assign fb_ibus.bexc  = fb_mbus.bexc;
    assign fb_dbus.bdata = fb_mbus.bdata;
    assign fb_dbus.bexc  = fb_mbus.bexc;

    // Byte-mask width sanity: the mask is one bit per data byte.
    logic [MW-1:0] unused_mw;
    assign unused_mw = fb_dbus.awmsk & {MW{1'b0}};

endmodule

// File: tb/tb_fb_bus_arbiter.sv
module tb_fb_bus_arbiter;
    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MEM_DELAY = 2;
    localparam int BUDGET    = 100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fb_bus_arbiter_if #(.AW(AW), .DW(DW)) ibus ();
    fb_bus_arbiter_if #(.AW(AW), .DW(DW)) dbus ();
    fb_bus_arbiter_if #(.AW(AW), .DW(DW)) mbus ();

    fb_bus_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .fb_ibus (ibus),
        .fb_dbus (dbus),
        .fb_mbus (mbus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- memory slave model ----------------
    logic [31:0]   mem [logic [31:0]];
    logic          s_busy   = 1'b0;
    logic          s_bvalid = 1'b0;
    int            s_cnt    = 0;
    logic [DW-1:0] s_bdata  = '0;
    logic [1:0]    s_bexc   = '0;
    logic [31:0]   wtmp;

    assign mbus.aready = !s_busy;
    assign mbus.bvalid = s_bvalid;
    assign mbus.bdata  = s_bdata;
    assign mbus.bexc   = s_bexc;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : ~a;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            s_busy   <= 1'b0;
            s_bvalid <= 1'b0;
            s_cnt    <= 0;
        end else if (!s_busy) begin
            if (mbus.avalid) begin
                s_busy <= 1'b1;
                s_cnt  <= MEM_DELAY;
                s_bexc <= mbus.aexc;
                if (mbus.awmsk != '0) begin
                    wtmp = mem_rd(mbus.aaddr);
                    for (int b = 0; b < 4; b++)
                        if (mbus.awmsk[b]) wtmp[8*b +: 8] = mbus.adata[8*b +: 8];
                    mem[mbus.aaddr] = wtmp;
                    s_bdata <= '0;
                end else begin
                    s_bdata <= mem_rd(mbus.aaddr);
                end
            end
        end else if (!s_bvalid) begin
            if (s_cnt == 0) s_bvalid <= 1'b1;
            else            s_cnt    <= s_cnt - 1;
        end else if (mbus.bready) begin
            s_bvalid <= 1'b0;
            s_busy   <= 1'b0;
        end
    end

    // ---------------- monitor (sampled at negedge) ----------------
    int  cyc = 0;
    byte grant_log[$];
    int  i_bv_cnt = 0, d_bv_cnt = 0, both_ar = 0;
    int  i_ahs_cyc = -1, d_bhs_cyc = -1;

    always @(negedge clk) begin
        cyc++;
        if (ibus.avalid && ibus.aready) begin grant_log.push_back("I"); i_ahs_cyc = cyc; end
        if (dbus.avalid && dbus.aready) grant_log.push_back("D");
        if (ibus.bvalid) i_bv_cnt++;
        if (dbus.bvalid) d_bv_cnt++;
        if (ibus.aready && dbus.aready) both_ar++;
        if (dbus.bvalid && dbus.bready) d_bhs_cyc = cyc;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- master tasks ----------------
    task automatic ireq(input logic [31:0] addr, input logic [1:0] exc,
                        output logic [31:0] rdata, output logic [1:0] rexc);
        int n;
        ibus.aaddr  = addr;
        ibus.aexc   = exc;
        ibus.adata  = '1;
        ibus.awmsk  = '1;
        ibus.bready = 1'b1;
        ibus.avalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ibus.aready && n < BUDGET) begin @(negedge clk); n++; end
        check("ibus_accept_in_budget", n < BUDGET, 1);
        check("ibus_cmd_aaddr", mbus.aaddr, addr);
        check("ibus_cmd_awmsk", mbus.awmsk, 0);
        check("ibus_cmd_adata", mbus.adata, 0);
        check("ibus_cmd_aexc", mbus.aexc, exc);
        @(posedge clk); #1;
        ibus.avalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!ibus.bvalid && n < BUDGET) begin @(negedge clk); n++; end
        check("ibus_resp_in_budget", n < BUDGET, 1);
        check("ibus_resp_dbus_bvalid", dbus.bvalid, 0);
        rdata = ibus.bdata;
        rexc  = ibus.bexc;
        @(posedge clk); #1;
    endtask

    task automatic dreq(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] msk,
                        input logic [1:0] exc, output logic [31:0] rdata, output logic [1:0] rexc);
        int n;
        dbus.aaddr  = addr;
        dbus.adata  = data;
        dbus.awmsk  = msk;
        dbus.aexc   = exc;
        dbus.bready = 1'b1;
        dbus.avalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!dbus.aready && n < BUDGET) begin @(negedge clk); n++; end
        check("dbus_accept_in_budget", n < BUDGET, 1);
        check("dbus_cmd_aaddr", mbus.aaddr, addr);
        check("dbus_cmd_adata", mbus.adata, data);
        check("dbus_cmd_awmsk", mbus.awmsk, msk);
        check("dbus_cmd_aexc", mbus.aexc, exc);
        @(posedge clk); #1;
        dbus.avalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!dbus.bvalid && n < BUDGET) begin @(negedge clk); n++; end
        check("dbus_resp_in_budget", n < BUDGET, 1);
        check("dbus_resp_ibus_bvalid", ibus.bvalid, 0);
        rdata = dbus.bdata;
        rexc  = dbus.bexc;
        @(posedge clk); #1;
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] rd_i, rd_d, rd_i2, rd_d2;
    logic [1:0]  ex_i, ex_d, ex_i2, ex_d2;
    int          n, bv0;

    initial begin
        mem[32'h100] = 32'h1234_5678;
        rst = 1'b1;
        ibus.avalid = 0; ibus.aaddr = 0; ibus.adata = 0; ibus.awmsk = 0; ibus.aexc = 0; ibus.bready = 0;
        dbus.avalid = 0; dbus.aaddr = 0; dbus.adata = 0; dbus.awmsk = 0; dbus.aexc = 0; dbus.bready = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mbus_avalid", mbus.avalid, 0);
        check("rst_mbus_bready", mbus.bready, 0);
        check("rst_mbus_aaddr", mbus.aaddr, 0);
        check("rst_ibus_aready", ibus.aready, 0);
        check("rst_dbus_aready", dbus.aready, 0);
        check("rst_ibus_bvalid", ibus.bvalid, 0);
        check("rst_dbus_bvalid", dbus.bvalid, 0);
        check("rst_state", dut.state, 0);

        // 1) ibus only, exact arbitration and memory latency
        rst = 1'b0;
        ibus.aaddr = 32'h100; ibus.adata = '1; ibus.awmsk = '1; ibus.aexc = 0; ibus.bready = 1;
        ibus.avalid = 1'b1;
        #1;
        check("t1_idle_mbus_avalid", mbus.avalid, 0);
        check("t1_idle_ibus_aready", ibus.aready, 0);
        @(posedge clk); #1;
        check("t1_cmd_mbus_avalid", mbus.avalid, 1);
        check("t1_cmd_aaddr", mbus.aaddr, 32'h100);
        check("t1_cmd_awmsk", mbus.awmsk, 0);
        check("t1_cmd_adata", mbus.adata, 0);
        check("t1_cmd_ibus_aready", ibus.aready, 1);
        check("t1_cmd_dbus_aready", dbus.aready, 0);
        @(posedge clk); #1;
        ibus.avalid = 1'b0;
        check("t1_resp_state", dut.state, 2);
        check("t1_resp_mbus_avalid", mbus.avalid, 0);
        n = 0;
        @(negedge clk);
        while (!ibus.bvalid && n < BUDGET) begin @(negedge clk); n++; end
        check("t1_resp_latency", n, 3);
        check("t1_bdata", ibus.bdata, 32'h1234_5678);
        check("t1_mbus_bready", mbus.bready, 1);
        @(posedge clk); #1;
        check("t1_back_idle", dut.state, 0);
        check("t1_dbus_bvalid_never", d_bv_cnt, 0);

        // 2) dbus writes forwarded unchanged, response to dbus only, read back by ibus
        bv0 = i_bv_cnt;
        dreq(32'h200, 32'hDEAD_BEEF, 4'hF, 2'd2, rd_d, ex_d);
        check("t2_dbus_bexc", ex_d, 2);
        check("t2_ibus_bvalid_never", i_bv_cnt, bv0);
        ireq(32'h200, 2'd0, rd_i, ex_i);
        check("t2_readback", rd_i, 32'hDEAD_BEEF);
        dreq(32'h200, 32'h0000_00AA, 4'b0001, 2'd0, rd_d, ex_d);
        ireq(32'h200, 2'd3, rd_i, ex_i);
        check("t2_partial_readback", rd_i, 32'hDEAD_BEAA);
        check("t2_ibus_bexc", ex_i, 3);

        // 3) simultaneous requests right after reset: dbus first
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        grant_log.delete();
        i_ahs_cyc = -1; d_bhs_cyc = -1;
        fork
            ireq(32'h100, 2'd0, rd_i, ex_i);
            dreq(32'h300, 32'h0, 4'h0, 2'd1, rd_d, ex_d);
        join
        check("t3_first_grant", grant_log[0], "D");
        check("t3_second_grant", grant_log[1], "I");
        check("t3_ibus_after_dbus_b", i_ahs_cyc > d_bhs_cyc, 1);
        check("t3_dbus_rdata", rd_d, 32'hFFFF_FCFF);
        check("t3_dbus_bexc", ex_d, 1);
        check("t3_ibus_rdata", rd_i, 32'h1234_5678);

        // 4) both continuously requesting: D, I, D, I
        grant_log.delete();
        fork
            begin repeat (2) ireq(32'h100, 2'd0, rd_i2, ex_i2); end
            begin repeat (2) dreq(32'h200, 32'h0, 4'h0, 2'd0, rd_d2, ex_d2); end
        join
        check("t4_n_grants", grant_log.size(), 4);
        check("t4_grant0", grant_log[0], "D");
        check("t4_grant1", grant_log[1], "I");
        check("t4_grant2", grant_log[2], "D");
        check("t4_grant3", grant_log[3], "I");
        check("t4_dbus_rdata", rd_d2, 32'hDEAD_BEAA);

        // 5) B backpressure on dbus
        dbus.aaddr = 32'h100; dbus.adata = 0; dbus.awmsk = 0; dbus.aexc = 0; dbus.bready = 0;
        dbus.avalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!dbus.aready && n < BUDGET) begin @(negedge clk); n++; end
        check("t5_accept_in_budget", n < BUDGET, 1);
        @(posedge clk); #1;
        dbus.avalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!mbus.bvalid && n < BUDGET) begin @(negedge clk); n++; end
        check("t5_mbus_bvalid_in_budget", n < BUDGET, 1);
        for (int k = 0; k < 3; k++) begin
            check("t5_bp_mbus_bready", mbus.bready, 0);
            check("t5_bp_dbus_bvalid", dbus.bvalid, 1);
            check("t5_bp_state", dut.state, 2);
            @(negedge clk);
        end
        @(posedge clk); #1;
        dbus.bready = 1'b1;
        #1;
        check("t5_release_mbus_bready", mbus.bready, 1);
        check("t5_release_bdata", dbus.bdata, 32'h1234_5678);
        check("t5_release_ibus_bvalid", ibus.bvalid, 0);
        @(posedge clk); #1;
        check("t5_done_dbus_bvalid", dbus.bvalid, 0);
        check("t5_done_state", dut.state, 0);

        // 6) reset while in RESP
        ibus.aaddr = 32'h200; ibus.adata = 0; ibus.awmsk = 0; ibus.aexc = 0; ibus.bready = 0;
        ibus.avalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ibus.aready && n < BUDGET) begin @(negedge clk); n++; end
        check("t6_accept_in_budget", n < BUDGET, 1);
        @(posedge clk); #1;
        ibus.avalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!mbus.bvalid && n < BUDGET) begin @(negedge clk); n++; end
        check("t6_pending_resp", mbus.bvalid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        ibus.bready = 1'b1;
        #1;
        check("t6_in_rst_ibus_bvalid", ibus.bvalid, 0);
        check("t6_in_rst_mbus_bready", mbus.bready, 0);
        check("t6_in_rst_mbus_avalid", mbus.avalid, 0);
        @(posedge clk); #1;
        check("t6_after_rst_state", dut.state, 0);
        check("t6_after_rst_ibus_bvalid", ibus.bvalid, 0);
        check("t6_after_rst_dbus_aready", dbus.aready, 0);
        rst = 1'b0;
        ireq(32'h100, 2'd0, rd_i, ex_i);
        check("t6_new_ibus_rdata", rd_i, 32'h1234_5678);

        check("no_dual_aready", both_ar, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
